app_mul_accumulate: RTL

//  Downstream consumer of the approximate 16x16 log multiplier's 32-bit product.

---
 rtl/app_mul_accumulate_pkg.sv | 22 ++
 rtl/app_mul_accumulate_if.sv | 31 +++
 rtl/app_acc_sat_add.sv | 40 ++++
 rtl/app_mul_accumulate.sv | 98 +++++++++
 4 files changed

// File: rtl/app_mul_accumulate_pkg.sv
// Shared types for the log-multiplier accumulate stage.
// Optional saturating mode: APP_MUL_ACC_SATURATE_EN (see app_acc_sat_add).
package app_mul_accumulate_pkg;

  localparam int unsigned ScalarWidth = 32;

  typedef logic [ScalarWidth-1:0] scalar_t;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_RUN,
    ACC_RESULT
  } app_acc_state_t;

  // Sign- or zero-extend a product into an accumulator-width operand.
  function automatic logic [63:0] ext_product(input scalar_t product, input logic sign);
    logic [63:0] wide;
    wide = sign ? {{32{product[ScalarWidth-1]}}, product} : {32'h0, product};
    return wide;
  endfunction

endpackage

// File: rtl/app_mul_accumulate_if.sv
// Input product stream and output result handshake of the accumulate stage.
interface app_mul_accumulate_if #(
  parameter int unsigned ACC_WIDTH = 40,
  parameter int unsigned MAX_COUNT = 256
);
  import app_mul_accumulate_pkg::*;

  localparam int unsigned CntWidth = $clog2(MAX_COUNT + 1);

  logic                 in_valid;
  logic                 in_ready;
  scalar_t              in_product;
  logic                 in_sign;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_result;
  logic [CntWidth-1:0]  out_count;
  logic                 out_overflow;

  modport master (
    output in_valid, in_product, in_sign, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_product, in_sign, in_last, out_ready,
    output in_ready, out_valid, out_result, out_count, out_overflow
  );

endinterface

// File: rtl/app_acc_sat_add.sv
// Combinational signed accumulator adder with overflow detect.
// APP_MUL_ACC_SATURATE_EN clamps the sum to the signed range on overflow.
module app_acc_sat_add #(
  parameter int unsigned ACC_WIDTH = 40
) (
  input  logic [ACC_WIDTH-1:0] a_i,
  input  logic [ACC_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 overflow_o
);

  logic [ACC_WIDTH-1:0] raw_sum;
  logic                 ovf;

  always_comb begin
    raw_sum = a_i + b_i;
    // Same operand signs but a different result sign means two's complement overflow.
    ovf     = (a_i[ACC_WIDTH-1] == b_i[ACC_WIDTH-1]) &&
              (raw_sum[ACC_WIDTH-1] != a_i[ACC_WIDTH-1]);
  end

`ifdef APP_MUL_ACC_SATURATE_EN
  logic [ACC_WIDTH-1:0] sat_max;
  logic [ACC_WIDTH-1:0] sat_min;

  always_comb begin
    sat_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    sat_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    sum_o   = raw_sum;
    if (ovf) begin
      sum_o = a_i[ACC_WIDTH-1] ? sat_min : sat_max;
    end
  end
`else
  assign sum_o = raw_sum;
`endif

  assign overflow_o = ovf;

endmodule

// File: rtl/app_mul_accumulate.sv
// Accumulates a stream of 32-bit products into groups and returns sum, count and overflow.
// Saturating accumulation is selected with APP_MUL_ACC_SATURATE_EN.
module app_mul_accumulate
  import app_mul_accumulate_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 40,
  parameter int unsigned MAX_COUNT = 256
) (
  input logic                 clk,
  input logic                 reset,
  app_mul_accumulate_if.slave bus
);

  localparam int unsigned CntWidth = $clog2(MAX_COUNT + 1);

  app_acc_state_t       state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CntWidth-1:0]  count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic [63:0]          prod_wide;
  logic [ACC_WIDTH-1:0] operand;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_ovf;
  logic                 in_fire;
  logic                 end_group;

  always_comb begin
    prod_wide = ext_product(bus.in_product, bus.in_sign);
    operand   = prod_wide[ACC_WIDTH-1:0];
  end

  app_acc_sat_add #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_add (
    .a_i        (acc_q),
    .b_i        (operand),
    .sum_o      (add_sum),
    .overflow_o (add_ovf)
  );

  assign in_fire   = bus.in_valid && (state_q != ACC_RESULT);
  assign end_group = bus.in_last || (count_q == CntWidth'(MAX_COUNT - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ACC_IDLE, ACC_RUN: begin
        if (in_fire) begin
          acc_d   = add_sum;
          count_d = count_q + CntWidth'(1);
          ovf_d   = ovf_q | add_ovf;
          state_d = end_group ? ACC_RESULT : ACC_RUN;
        end
      end
      ACC_RESULT: begin
        // Clearing here keeps the next group starting from zero without a restart path.
        if (bus.out_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ACC_IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        count_d = '0;
        ovf_d   = 1'b0;
        state_d = ACC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACC_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs are pure register decodes, so they hold while the consumer stalls.
  assign bus.in_ready     = (state_q != ACC_RESULT);
  assign bus.out_valid    = (state_q == ACC_RESULT);
  assign bus.out_result   = acc_q;
  assign bus.out_count    = count_q;
  assign bus.out_overflow = ovf_q;

endmodule
